// File: rtl/l3_chunk_loader.sv
// UART command parser that feeds the L3 voxel cache. It issues one-hot X/Z scroll commands
// and streams block payloads into the cache as relative-coordinate writes.
module l3_chunk_loader #(
    parameter int unsigned LENGTH         = 64,
    parameter int unsigned WIDTH          = 64,
    parameter int unsigned HEIGHT         = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [7:0]                byte_in,
    input  logic                      byte_valid_in,
    output logic [$clog2(LENGTH)-1:0] xwrite,
    output logic [$clog2(HEIGHT)-1:0] ywrite,
    output logic [$clog2(WIDTH)-1:0]  zwrite,
    output logic [7:0]                data_out,
    output logic                      write_enable,
    output logic [3:0]                control_input,
    output logic                      control_trigger,
    output logic                      valid_out,
    output logic                      busy_out,
    output logic                      done_out,
    output logic                      err_out
);
    localparam int unsigned XW = $clog2(LENGTH);
    localparam int unsigned YW = $clog2(HEIGHT);
    localparam int unsigned ZW = $clog2(WIDTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [XW-1:0] XMAX  = XW'(LENGTH - 1);
    localparam logic [YW-1:0] YMAX  = YW'(HEIGHT - 1);
    localparam logic [ZW-1:0] ZMAX  = ZW'(WIDTH - 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StCmd, StScroll, StLoad} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cmd_q, cmd_d;
    logic [XW-1:0] x_q, x_d, xw_q, xw_d;
    logic [YW-1:0] y_q, y_d, yw_q, yw_d;
    logic [ZW-1:0] z_q, z_d, zw_q, zw_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    data_q, data_d;
    logic [3:0]    ctl_q, ctl_d;
    logic          we_q, we_d, trig_q, trig_d, done_q, done_d, err_q, err_d;
    logic          last;

    // Final byte of the frame depends on which volume the command streams.
    always_comb begin
        last = 1'b0;
        case (cmd_q)
            4'h1, 4'h2: last = (y_q == YMAX) && (z_q == ZMAX);
            4'h4, 4'h8: last = (y_q == YMAX) && (x_q == XMAX);
            default:    last = (x_q == XMAX) && (y_q == YMAX) && (z_q == ZMAX);
        endcase
    end

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        tmo_d   = '0;
        xw_d    = xw_q;
        yw_d    = yw_q;
        zw_d    = zw_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ctl_d   = 4'h0;
        trig_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (byte_valid_in && byte_in == 8'hA5) state_d = StCmd;
            end
            StCmd: begin
                tmo_d = tmo_q + TW'(1);
                if (byte_valid_in) begin
                    tmo_d = '0;
                    cmd_d = byte_in[3:0];
                    x_d   = '0;
                    y_d   = '0;
                    z_d   = '0;
                    case (byte_in)
                        8'h00: state_d = StLoad;
                        8'h01, 8'h02, 8'h04, 8'h08: begin
                            state_d = StScroll;
                            trig_d  = 1'b1;
                            ctl_d   = byte_in[3:0];
                            if (byte_in == 8'h01) x_d = XMAX;
                            if (byte_in == 8'h04) z_d = ZMAX;
                        end
                        default: begin
                            state_d = StIdle;
                            err_d   = 1'b1;
                        end
                    endcase
                end else if (tmo_q == TLAST) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            StScroll: state_d = StLoad;
            StLoad: begin
                tmo_d = tmo_q + TW'(1);
                if (byte_valid_in) begin
                    tmo_d  = '0;
                    we_d   = 1'b1;
                    xw_d   = x_q;
                    yw_d   = y_q;
                    zw_d   = z_q;
                    data_d = byte_in;
                    // Extents are powers of two, so counters wrap naturally.
                    case (cmd_q)
                        4'h1, 4'h2: begin
                            z_d = z_q + ZW'(1);
                            if (z_q == ZMAX) y_d = y_q + YW'(1);
                        end
                        4'h4, 4'h8: begin
                            x_d = x_q + XW'(1);
                            if (x_q == XMAX) y_d = y_q + YW'(1);
                        end
                        default: begin
                            z_d = z_q + ZW'(1);
                            if (z_q == ZMAX) begin
                                y_d = y_q + YW'(1);
                                if (y_q == YMAX) x_d = x_q + XW'(1);
                            end
                        end
                    endcase
                    if (last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end else if (tmo_q == TLAST) begin
                    state_d = StIdle;
                    err_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= StIdle;
            cmd_q   <= 4'h0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            tmo_q   <= '0;
            xw_q    <= '0;
            yw_q    <= '0;
            zw_q    <= '0;
            data_q  <= 8'h00;
            we_q    <= 1'b0;
            ctl_q   <= 4'h0;
            trig_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            tmo_q   <= tmo_d;
            xw_q    <= xw_d;
            yw_q    <= yw_d;
            zw_q    <= zw_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ctl_q   <= ctl_d;
            trig_q  <= trig_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign xwrite          = xw_q;
    assign ywrite          = yw_q;
    assign zwrite          = zw_q;
    assign data_out        = data_q;
    assign write_enable    = we_q;
    assign control_input   = ctl_q;
    assign control_trigger = trig_q;
    assign valid_out       = trig_q;
    assign busy_out        = (state_q != StIdle);
    assign done_out        = done_q;
    assign err_out         = err_q;
endmodule

// File: tb/tb_l3_chunk_loader.sv
// Directed-plus-random bench for l3_chunk_loader on a 4x2x4 volume with a short timeout.
// Expected coordinates come from plain index arithmetic over the payload position.
module tb_l3_chunk_loader;
    localparam int L = 4;
    localparam int W = 4;
    localparam int H = 2;
    localparam int T = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           byte_in = 8'h00;
    logic                 bv = 1'b0;
    logic [$clog2(L)-1:0] xw;
    logic [$clog2(H)-1:0] yw;
    logic [$clog2(W)-1:0] zw;
    logic [7:0]           data;
    logic                 we, trig, vld, busy, done, err;
    logic [3:0]           ctl;

    int checks = 0;
    int failures = 0;
    int n_wr = 0, n_trig = 0, n_done = 0, n_err = 0;

    l3_chunk_loader #(.LENGTH(L), .WIDTH(W), .HEIGHT(H), .TIMEOUT_CYCLES(T)) dut (
        .clk_in(clk), .rst_in(rst_n), .byte_in(byte_in), .byte_valid_in(bv),
        .xwrite(xw), .ywrite(yw), .zwrite(zw), .data_out(data), .write_enable(we),
        .control_input(ctl), .control_trigger(trig), .valid_out(vld),
        .busy_out(busy), .done_out(done), .err_out(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we)   n_wr++;
        if (trig) n_trig++;
        if (done) n_done++;
        if (err)  n_err++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        byte_in = b;
        bv = 1'b1;
        @(posedge clk);
        #1;
        bv = 1'b0;
    endtask

    function automatic int plen(input int cmd);
        if (cmd == 0) return L * H * W;
        if (cmd == 1 || cmd == 2) return H * W;
        return L * H;
    endfunction

    task automatic coord(input int cmd, input int k, output int x, output int y, output int z);
        case (cmd)
            0: begin x = k / (H * W); y = (k / W) % H; z = k % W; end
            1: begin x = L - 1; y = k / W; z = k % W; end
            2: begin x = 0;     y = k / W; z = k % W; end
            4: begin z = W - 1; y = k / L; x = k % L; end
            default: begin z = 0; y = k / L; x = k % L; end
        endcase
    endtask

    // Sends one frame; nbytes < plen(cmd) leaves it unfinished. a5_at forces a 0xA5 data byte.
    task automatic frame(input int cmd, input int nbytes, input int a5_at, input bit seq);
        int x, y, z, n;
        int wr0, tr0, dn0;
        logic [7:0] d;
        n = plen(cmd);
        wr0 = n_wr; tr0 = n_trig; dn0 = n_done;
        send(8'hA5);
        chk("busy_after_sync", busy, 1);
        chk("no_write_sync", we, 0);
        send(cmd[7:0]);
        chk("busy_after_cmd", busy, 1);
        chk("trigger", trig, (cmd != 0) ? 1 : 0);
        chk("valid_out", vld, (cmd != 0) ? 1 : 0);
        chk("control_code", ctl, (cmd != 0) ? cmd : 0);
        chk("no_write_cmd", we, 0);
        if (cmd != 0) begin
            @(posedge clk);
            #1;
            chk("trigger_falls", trig, 0);
            chk("control_code_clears", ctl, 0);
        end
        for (int k = 0; k < nbytes; k++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            d = seq ? 8'(k) : 8'($urandom);
            if (k == a5_at) d = 8'hA5;
            send(d);
            coord(cmd, k, x, y, z);
            chk("write_enable", we, 1);
            chk("xwrite", xw, x);
            chk("ywrite", yw, y);
            chk("zwrite", zw, z);
            chk("data_out", data, d);
            chk("done_out", done, (k == n - 1) ? 1 : 0);
            chk("busy_during_load", busy, (k == n - 1) ? 0 : 1);
            chk("no_trigger_load", trig, 0);
        end
        @(negedge clk);
        #1;
        if (nbytes == n) begin
            chk("write_count", n_wr - wr0, n);
            chk("trigger_count", n_trig - tr0, (cmd != 0) ? 1 : 0);
            chk("done_count", n_done - dn0, 1);
        end
    endtask

    initial begin
        int e0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_x", xw, 0);
        chk("rst_y", yw, 0);
        chk("rst_z", zw, 0);
        chk("rst_data", data, 0);
        chk("rst_ctl", ctl, 0);
        chk("rst_trig", trig, 0);
        chk("rst_valid", vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h11);
        chk("idle_ignore_we", we, 0);
        chk("idle_ignore_busy", busy, 0);

        frame(0, 32, -1, 1'b1);
        frame(1, 8, -1, 1'b0);
        frame(8, 8, -1, 1'b0);
        frame(2, 8, 3, 1'b0);
        frame(4, 8, -1, 1'b0);

        e0 = n_err;
        send(8'hA5);
        send(8'h03);
        chk("bad_cmd_err", err, 1);
        chk("bad_cmd_busy", busy, 0);
        chk("bad_cmd_we", we, 0);
        chk("bad_cmd_trig", trig, 0);
        @(posedge clk);
        #1;
        chk("bad_cmd_err_pulse", err, 0);
        chk("bad_cmd_err_count", n_err - e0, 1);
        frame(2, 8, -1, 1'b0);

        frame(0, 5, -1, 1'b0);
        for (int i = 1; i < T; i++) begin
            @(posedge clk);
            #1;
            chk("timeout_early", err, 0);
        end
        @(posedge clk);
        #1;
        chk("timeout_err", err, 1);
        chk("timeout_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("timeout_err_pulse", err, 0);
        send(8'h11);
        chk("stray_we", we, 0);
        chk("stray_busy", busy, 0);
        frame(0, 32, 7, 1'b0);

        frame(0, 6, 4, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", we, 0);
        chk("async_rst_x", xw, 0);
        chk("async_rst_z", zw, 0);
        chk("async_rst_data", data, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h11);
        chk("post_rst_we", we, 0);
        chk("post_rst_busy", busy, 0);
        frame(0, 32, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
